// File: rtl/hrmpp_pkg.sv
// Shared constants and result typedef for the strip placement index pipeline.
package hrmpp_pkg;

  localparam int NUM_STRIPS_D   = 14;
  localparam int WIDTH_W_D      = 8;
  localparam int STRIP_LEN_D    = 200;
  localparam int STRIP_HEIGHT_D = 16;
  localparam int Y_W_D          = 8;
  localparam int CNT_W_D        = 4;

  // Index value reported for a request that did not fit or named a bad strip
  localparam logic [WIDTH_W_D-1:0] STRIKE_IDX = '1;

  typedef struct packed {
    logic                 strike;
    logic [CNT_W_D-1:0]   strike_cnt;
    logic [WIDTH_W_D-1:0] x;
    logic [Y_W_D-1:0]     y;
  } result_t;

endpackage

// File: rtl/strip_occ_table.sv
// Per-strip occupancy register file: one async read, one write, sync active-low clear.
// Optional per-entry clear port when OCC_CLEAR_EN is defined.
module strip_occ_table
  import hrmpp_pkg::*;
#(
  parameter int NUM_STRIPS = NUM_STRIPS_D,
  parameter int WIDTH_W    = WIDTH_W_D,
  parameter int ID_W       = $clog2(NUM_STRIPS_D)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [ID_W-1:0]    i_rd_idx,
  output logic [WIDTH_W-1:0] o_rd_data,
`ifdef OCC_CLEAR_EN
  input  logic               i_clr,
  input  logic [ID_W-1:0]    i_clr_idx,
`endif
  input  logic               i_we,
  input  logic [ID_W-1:0]    i_wr_idx,
  input  logic [WIDTH_W-1:0] i_wr_data
);

  logic [WIDTH_W-1:0] r_occ [NUM_STRIPS];

  // Out-of-range reads return zero rather than an undefined entry
  assign o_rd_data = (32'(i_rd_idx) < 32'(NUM_STRIPS)) ? r_occ[i_rd_idx] : '0;

  // Table update: reset clears all, then write, then clear (clear overrides a same-edge write)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_STRIPS; i++) r_occ[i] <= '0;
    end else begin
      if (i_we && (32'(i_wr_idx) < 32'(NUM_STRIPS))) r_occ[i_wr_idx] <= i_wr_data;
`ifdef OCC_CLEAR_EN
      if (i_clr && (32'(i_clr_idx) < 32'(NUM_STRIPS))) r_occ[i_clr_idx] <= '0;
`endif
    end
  end

endmodule

// File: rtl/strip_place_index_pipe.sv
// Strip placement index pipeline: fit check + occupancy RMW at accept, (x,y) mapping,
// 3-stage elastic valid/ready pipeline. Optional macro OCC_CLEAR_EN adds a strip clear port.
module strip_place_index_pipe
  import hrmpp_pkg::*;
#(
  parameter int NUM_STRIPS   = NUM_STRIPS_D,
  parameter int WIDTH_W      = WIDTH_W_D,
  parameter int STRIP_LEN    = STRIP_LEN_D,
  parameter int STRIP_HEIGHT = STRIP_HEIGHT_D,
  parameter int Y_W          = Y_W_D,
  parameter int CNT_W        = CNT_W_D,
  localparam int ID_W        = $clog2(NUM_STRIPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ID_W-1:0]    in_strip_id,
  input  logic [WIDTH_W-1:0] in_prog_width,
  input  logic [CNT_W-1:0]   in_strike_cnt,
`ifdef OCC_CLEAR_EN
  input  logic               clr_valid,
  input  logic [ID_W-1:0]    clr_strip_id,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_W-1:0] out_x,
  output logic [Y_W-1:0]     out_y,
  output logic               out_strike,
  output logic [CNT_W-1:0]   out_strike_cnt
);

  function automatic logic fits(input logic [ID_W-1:0] id, input logic [WIDTH_W:0] sum);
    return (32'(id) < 32'(NUM_STRIPS)) && (sum <= (WIDTH_W+1)'(STRIP_LEN));
  endfunction

  function automatic logic [Y_W-1:0] y_index(input logic [ID_W-1:0] id);
    logic [31:0] prod;
    prod = 32'(id) * 32'(STRIP_HEIGHT);
    return prod[Y_W-1:0];
  endfunction

  logic [WIDTH_W-1:0] w_occ_rd;
  logic [WIDTH_W:0]   w_sum;
  logic               w_fit;
  logic               w_accept;
  logic               w_rdy_p0, w_rdy_p1, w_rdy_p2;

  logic               r_vld_p0, r_vld_p1, r_vld_p2;
  logic [ID_W-1:0]    r_id_p0;
  logic [WIDTH_W-1:0] r_x_p0, r_x_p1, r_x_p2;
  logic [Y_W-1:0]     r_y_p1, r_y_p2;
  logic               r_strike_p0, r_strike_p1, r_strike_p2;
  logic [CNT_W-1:0]   r_cnt_p0, r_cnt_p1, r_cnt_p2;

  assign w_rdy_p2 = ~r_vld_p2 | out_ready;
  assign w_rdy_p1 = ~r_vld_p1 | w_rdy_p2;
  assign w_rdy_p0 = ~r_vld_p0 | w_rdy_p1;
  assign in_ready = rst & w_rdy_p0;
  assign w_accept = in_valid & in_ready;

  // Occupancy table: the write lands on the accept edge, so the next request sees it directly
  assign w_sum = {1'b0, w_occ_rd} + {1'b0, in_prog_width};
  assign w_fit = fits(in_strip_id, w_sum);

  strip_occ_table #(
    .NUM_STRIPS(NUM_STRIPS),
    .WIDTH_W   (WIDTH_W),
    .ID_W      (ID_W)
  ) u_occ (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_rd_idx (in_strip_id),
    .o_rd_data(w_occ_rd),
`ifdef OCC_CLEAR_EN
    .i_clr    (clr_valid),
    .i_clr_idx(clr_strip_id),
`endif
    .i_we     (w_accept & w_fit),
    .i_wr_idx (in_strip_id),
    .i_wr_data(w_sum[WIDTH_W-1:0])
  );

  // Stage valids advance whenever the downstream stage can take them
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_rdy_p0) r_vld_p0 <= w_accept;
      if (w_rdy_p1) r_vld_p1 <= r_vld_p0;
      if (w_rdy_p2) r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- Stage 1: capture old occupancy and fit result at accept ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_id_p0     <= in_strip_id;
      r_x_p0      <= w_occ_rd;
      r_strike_p0 <= ~w_fit;
      r_cnt_p0    <= in_strike_cnt;
    end
  end

  // ---- Stage 2: map strip to y, force strike results to the all-ones index ----
  always_ff @(posedge clk) begin
    if (w_rdy_p1 && r_vld_p0) begin
      r_x_p1      <= r_strike_p0 ? '1 : r_x_p0;
      r_y_p1      <= r_strike_p0 ? '1 : y_index(r_id_p0);
      r_strike_p1 <= r_strike_p0;
      r_cnt_p1    <= r_cnt_p0;
    end
  end

  // ---- Stage 3: output register, held while the sink stalls ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x_p2      <= '0;
      r_y_p2      <= '0;
      r_strike_p2 <= 1'b0;
      r_cnt_p2    <= '0;
    end else if (w_rdy_p2 && r_vld_p1) begin
      r_x_p2      <= r_x_p1;
      r_y_p2      <= r_y_p1;
      r_strike_p2 <= r_strike_p1;
      r_cnt_p2    <= r_cnt_p1;
    end
  end

  assign out_valid      = r_vld_p2;
  assign out_x          = r_x_p2;
  assign out_y          = r_y_p2;
  assign out_strike     = r_strike_p2;
  assign out_strike_cnt = r_cnt_p2;

endmodule

// File: tb/tb_strip_place_index_pipe.sv
// Scoreboard bench for strip_place_index_pipe; clear-port tests build when OCC_CLEAR_EN is defined.
module tb_strip_place_index_pipe;
  import hrmpp_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_strip_id = '0;
  logic [7:0] in_prog_width = '0;
  logic [3:0] in_strike_cnt = '0;
  logic       clr_valid = 1'b0;
  logic [3:0] clr_strip_id = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_x;
  logic [7:0] out_y;
  logic       out_strike;
  logic [3:0] out_strike_cnt;

  result_t exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  strip_place_index_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_strip_id   (in_strip_id),
    .in_prog_width (in_prog_width),
    .in_strike_cnt (in_strike_cnt),
`ifdef OCC_CLEAR_EN
    .clr_valid     (clr_valid),
    .clr_strip_id  (clr_strip_id),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_strike    (out_strike),
    .out_strike_cnt(out_strike_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one request; expected result is queued once the DUT shows it will accept.
  task automatic send(input logic [3:0] id, input logic [7:0] w, input logic [3:0] cnt,
                      input logic [7:0] ex, input logic [7:0] ey, input logic es,
                      input logic clr = 1'b0, input logic [3:0] cid = 4'd0);
    int waited;
    result_t r;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_strip_id = id; in_prog_width = w; in_strike_cnt = cnt;
    clr_valid = clr; clr_strip_id = cid;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout id=%0d width=%0d actual=not_ready expected=ready", id, w);
    end else begin
      r.strike = es; r.strike_cnt = cnt; r.x = ex; r.y = ey;
      exp_q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clr_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare the presented result to the queue head; pop on handshake
  initial begin
    result_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=x%0h/y%0h/s%0d expected=none", out_x, out_y, out_strike);
        end else begin
          e = exp_q[0];
          chk("out_x", out_x, e.x);
          chk("out_y", out_y, e.y);
          chk("out_strike", out_strike, e.strike);
          chk("out_strike_cnt", out_strike_cnt, e.strike_cnt);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_strike", out_strike, 0);
    chk("rst_out_cnt", out_strike_cnt, 0);
    rst = 1'b1;

    // First request and its latency
    send(4'd3, 8'd20, 4'd5, 8'd0, 8'd48, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_after_1", out_valid, 0);
    @(negedge clk);
    #1 chk("lat_after_2", out_valid, 0);
    @(negedge clk);
    #1 chk("lat_after_3", out_valid, 1);
    wait_drain();

    // Back-to-back accumulation up to exactly STRIP_LEN, then overflow
    send(4'd3, 8'd30,  4'd1, 8'd20,  8'd48,  1'b0);
    send(4'd3, 8'd150, 4'd2, 8'd50,  8'd48,  1'b0);
    send(4'd3, 8'd1,   4'd3, 8'hFF,  8'hFF,  1'b1);
    send(4'd3, 8'd0,   4'd4, 8'd200, 8'd48,  1'b0);
    // Bad ids, last strip, and no-wrap sum
    send(4'd14, 8'd1,   4'd6,  8'hFF, 8'hFF,  1'b1);
    send(4'd13, 8'd0,   4'd7,  8'd0,  8'd208, 1'b0);
    send(4'd15, 8'd0,   4'd8,  8'hFF, 8'hFF,  1'b1);
    send(4'd13, 8'd200, 4'd9,  8'd0,  8'd208, 1'b0);
    send(4'd13, 8'd1,   4'd10, 8'hFF, 8'hFF,  1'b1);
    send(4'd0,  8'd255, 4'd11, 8'hFF, 8'hFF,  1'b1);
    send(4'd0,  8'd200, 4'd12, 8'd0,  8'd0,   1'b0);
    send(4'd0,  8'd255, 4'd13, 8'hFF, 8'hFF,  1'b1);
    idle(1);
    wait_drain();

    // Backpressure: sink stalled for 6 cycles with continuous requests
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(4'd1, 8'd10, 4'(i), 8'(10 * i), 8'd16, 1'b0);
        idle(1);
      end
      begin
        repeat (6) @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with results in flight
    send(4'd2, 8'd5, 4'd1, 8'd0, 8'd32, 1'b0);
    send(4'd2, 8'd5, 4'd2, 8'd5, 8'd32, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_x", out_x, 0);
    @(negedge clk);
    rst = 1'b1;
    send(4'd2, 8'd7, 4'd3, 8'd0, 8'd48 - 8'd16, 1'b0);
    send(4'd3, 8'd1, 4'd4, 8'd0, 8'd48, 1'b0);
    idle(1);
    wait_drain();

`ifdef OCC_CLEAR_EN
    // Clear racing an accept on the same strip, then an out-of-range clear
    send(4'd3, 8'd39, 4'd5, 8'd1,  8'd48, 1'b0);
    send(4'd3, 8'd10, 4'd6, 8'd40, 8'd48, 1'b0, 1'b1, 4'd3);
    send(4'd3, 8'd5,  4'd7, 8'd0,  8'd48, 1'b0, 1'b1, 4'd15);
    send(4'd3, 8'd0,  4'd8, 8'd5,  8'd48, 1'b0);
    idle(1);
    wait_drain();
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
